afu_operand_packer: RTL and testbench

//   Producer side of the AFU operand-stream interface. Accepts 16-bit operand pairs (a,b) over a

---
 rtl/afu_pkg.sv | 14 +
 rtl/afu_operand_packer.sv | 92 +++++++++
 tb/tb_afu_operand_packer.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_pkg.sv
// afu_pkg: shared types and helpers for the AFU operand-stream producer.
package afu_pkg;

   typedef enum logic [1:0] {IDLE, FILL, PUSH, DONE} packer_state_e;

   localparam int DEF_DATA_WIDTH = 16;
   localparam int DEF_LINE_WIDTH = 512;
   localparam int LANE_WIDTH     = 2 * DEF_DATA_WIDTH;

   function automatic int lanes_per_line(input int line_width, input int data_width);
      return line_width / (2 * data_width);
   endfunction

endpackage

// File: rtl/afu_operand_packer.sv
// afu_operand_packer: packs {b,a} operand pairs into FIFO lines, zero-pads and flushes the
// final partial line, and pulses done once the whole context has been written.
module afu_operand_packer
   import afu_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int LINE_WIDTH     = 512,
   parameter int PAIRS_PER_LINE = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  start,
   input  logic [31:0]           ctx_length,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_a,
   input  logic [DATA_WIDTH-1:0] in_b,
   output logic [LINE_WIDTH-1:0] fifo_din,
   output logic                  fifo_we,
   input  logic                  fifo_full,
   input  logic                  fifo_almost_full,
   output logic                  busy,
   output logic                  done,
   output logic [31:0]           lines_written
);

   localparam int LW = 2 * DATA_WIDTH;
   localparam int CW = PAIRS_PER_LINE > 1 ? $clog2(PAIRS_PER_LINE) : 1;

   if (PAIRS_PER_LINE < 1 || PAIRS_PER_LINE > lanes_per_line(LINE_WIDTH, DATA_WIDTH)) begin : g_bad_cfg
      $error("PAIRS_PER_LINE lanes do not fit in LINE_WIDTH");
   end

   packer_state_e   state, state_nxt;
   logic [LINE_WIDTH-1:0] line;
   logic [CW-1:0]   lane_cnt;
   logic [31:0]     remaining;
   logic            accept;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: state_nxt = !start ? IDLE : (ctx_length != 32'd0 ? FILL : DONE);
         FILL: state_nxt = accept && (lane_cnt == CW'(PAIRS_PER_LINE - 1) || remaining == 32'd1) ? PUSH : FILL;
         PUSH: state_nxt = !fifo_we ? PUSH : (remaining == 32'd0 ? DONE : FILL);
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Full is checked on its own so a mis-set almost_full can never cause an overflow.
   always_comb begin
      in_ready = state == FILL;
      fifo_we  = state == PUSH && !fifo_almost_full && !fifo_full;
      busy     = state != IDLE;
      done     = state == DONE;
      accept   = in_valid && in_ready;
      fifo_din = line;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line          <= '0;
         lane_cnt      <= '0;
         remaining     <= '0;
         lines_written <= '0;
      end else begin
         if (state == IDLE && start) begin
            remaining     <= ctx_length;
            lines_written <= '0;
            line          <= '0;
            lane_cnt      <= '0;
         end
         if (accept) begin
            line[lane_cnt*LW +: LW] <= {in_b, in_a};
            lane_cnt  <= lane_cnt + CW'(1);
            remaining <= remaining - 32'd1;
         end
         if (fifo_we) begin
            lines_written <= lines_written + 32'd1;
            line          <= '0;
            lane_cnt      <= '0;
         end
      end
   end

endmodule

// File: tb/tb_afu_operand_packer.sv
// tb_afu_operand_packer: directed checks of the operand packer, default and one-pair-per-line builds.
module tb_afu_operand_packer;

   logic         clk = 0;
   logic         reset_n;
   logic         start, in_valid, in_ready, fifo_we, fifo_full, fifo_almost_full, busy, done;
   logic [31:0]  ctx_length, lines_written;
   logic [15:0]  in_a, in_b;
   logic [511:0] fifo_din;

   logic         start_1, in_valid_1, in_ready_1, fifo_we_1, busy_1, done_1;
   logic [31:0]  ctx_length_1, lines_written_1;
   logic [15:0]  in_a_1, in_b_1;
   logic [511:0] fifo_din_1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   afu_operand_packer u_dut (
      .clk(clk), .reset_n(reset_n), .start(start), .ctx_length(ctx_length),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .fifo_din(fifo_din), .fifo_we(fifo_we), .fifo_full(fifo_full),
      .fifo_almost_full(fifo_almost_full), .busy(busy), .done(done),
      .lines_written(lines_written)
   );

   afu_operand_packer #(.PAIRS_PER_LINE(1)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .start(start_1), .ctx_length(ctx_length_1),
      .in_valid(in_valid_1), .in_ready(in_ready_1), .in_a(in_a_1), .in_b(in_b_1),
      .fifo_din(fifo_din_1), .fifo_we(fifo_we_1), .fifo_full(1'b0),
      .fifo_almost_full(1'b0), .busy(busy_1), .done(done_1),
      .lines_written(lines_written_1)
   );

   task automatic begin_ctx(input logic [31:0] len);
      start = 1; ctx_length = len;
      @(negedge clk);
      start = 0;
   endtask

   // Drives n back-to-back pairs a=abase+i, b=bbase+i, one per negedge.
   task automatic feed(input int n, input logic [15:0] abase, input logic [15:0] bbase);
      for (int i = 0; i < n; i++) begin
         in_valid = 1; in_a = abase + 16'(i); in_b = bbase + 16'(i);
         @(negedge clk);
      end
      in_valid = 0;
   endtask

   task automatic test_reset;
      reset_n = 0; start = 0; ctx_length = 0; in_valid = 0; in_a = 0; in_b = 0;
      fifo_full = 0; fifo_almost_full = 0;
      start_1 = 0; ctx_length_1 = 0; in_valid_1 = 0; in_a_1 = 0; in_b_1 = 0;
      @(negedge clk); #1;
      checks++;
      if ({in_ready, fifo_we, busy, done} !== 4'b0 || fifo_din !== '0 || lines_written !== 0) begin
         errors++;
         $display("FAIL reset: ready=%b we=%b busy=%b done=%b din_zero=%b lw=%0d, want all 0",
                  in_ready, fifo_we, busy, done, fifo_din == '0, lines_written);
      end
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
   endtask

   task automatic test_single_line;
      logic [511:0] exp = '0;
      for (int i = 0; i < 16; i++) exp[i*32 +: 32] = {16'h100 + 16'(i), 16'(i)};
      begin_ctx(16);
      checks++;
      if (in_ready !== 1'b1 || busy !== 1'b1) begin
         errors++; $display("FAIL fill_ready: ready=%b busy=%b, want 1 1", in_ready, busy);
      end
      feed(16, 16'h0, 16'h100);
      #1;
      checks++;
      if (fifo_we !== 1'b1 || in_ready !== 1'b0) begin
         errors++; $display("FAIL line1_we: we=%b ready=%b, want 1 0", fifo_we, in_ready);
      end
      checks++;
      if (fifo_din !== exp) begin
         errors++; $display("FAIL line1_data: got %h want %h", fifo_din, exp);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || lines_written !== 32'd1 || fifo_we !== 1'b0) begin
         errors++; $display("FAIL line1_done: done=%b lw=%0d we=%b, want 1 1 0", done, lines_written, fifo_we);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL line1_idle: done=%b busy=%b, want 0 0", done, busy);
      end
   endtask

   task automatic test_partial_line;
      logic [511:0] exp1 = '0;
      logic [511:0] exp2 = '0;
      for (int i = 0; i < 16; i++) exp1[i*32 +: 32] = {16'h300 + 16'(i), 16'h200 + 16'(i)};
      for (int i = 0; i < 4; i++) exp2[i*32 +: 32] = {16'h310 + 16'(i), 16'h210 + 16'(i)};
      begin_ctx(20);
      feed(16, 16'h200, 16'h300);
      #1;
      checks++;
      if (fifo_we !== 1'b1 || fifo_din !== exp1) begin
         errors++; $display("FAIL partial_l1: we=%b got %h want %h", fifo_we, fifo_din, exp1);
      end
      @(negedge clk);
      feed(4, 16'h210, 16'h310);
      #1;
      checks++;
      if (fifo_we !== 1'b1 || fifo_din !== exp2) begin
         errors++; $display("FAIL partial_l2: we=%b got %h want %h", fifo_we, fifo_din, exp2);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || lines_written !== 32'd2) begin
         errors++; $display("FAIL partial_done: done=%b lw=%0d, want 1 2", done, lines_written);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure;
      logic [511:0] exp = '0;
      int bad = 0;
      for (int i = 0; i < 16; i++) exp[i*32 +: 32] = {16'h4400 + 16'(i), 16'h4000 + 16'(i)};
      begin_ctx(16);
      fifo_almost_full = 1;
      feed(16, 16'h4000, 16'h4400);
      for (int c = 0; c < 10; c++) begin
         #1;
         if (fifo_we !== 1'b0 || in_ready !== 1'b0 || fifo_din !== exp) bad++;
         @(negedge clk);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL almost_full_hold: %0d bad cycles, want 0", bad);
      end
      fifo_almost_full = 0; fifo_full = 1; #1;
      checks++;
      if (fifo_we !== 1'b0) begin
         errors++; $display("FAIL full_block: we=%b, want 0", fifo_we);
      end
      @(negedge clk);
      fifo_full = 0; #1;
      checks++;
      if (fifo_we !== 1'b1 || fifo_din !== exp) begin
         errors++; $display("FAIL bp_release: we=%b got %h want %h", fifo_we, fifo_din, exp);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b1 || lines_written !== 32'd1) begin
         errors++; $display("FAIL bp_done: done=%b lw=%0d, want 1 1", done, lines_written);
      end
      @(negedge clk);
   endtask

   task automatic test_zero_and_restart;
      logic [511:0] exp = '0;
      for (int i = 0; i < 16; i++) exp[i*32 +: 32] = {16'h5800 + 16'(i), 16'h5000 + 16'(i)};
      begin_ctx(0);
      #1;
      checks++;
      if (done !== 1'b1 || busy !== 1'b1 || fifo_we !== 1'b0) begin
         errors++; $display("FAIL zero_done: done=%b busy=%b we=%b, want 1 1 0", done, busy, fifo_we);
      end
      @(negedge clk); #1;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || lines_written !== 32'd0) begin
         errors++; $display("FAIL zero_idle: done=%b busy=%b lw=%0d, want 0 0 0", done, busy, lines_written);
      end
      begin_ctx(16);
      start = 1; ctx_length = 5;
      in_valid = 1; in_a = 16'h5000; in_b = 16'h5800;
      @(negedge clk);
      start = 0;
      feed(15, 16'h5001, 16'h5801);
      #1;
      checks++;
      if (fifo_we !== 1'b1 || fifo_din !== exp) begin
         errors++; $display("FAIL restart_ignored: we=%b got %h want %h", fifo_we, fifo_din, exp);
      end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_async_reset;
      logic [511:0] exp = '0;
      for (int i = 0; i < 16; i++) exp[i*32 +: 32] = {16'h6800 + 16'(i), 16'h6000 + 16'(i)};
      begin_ctx(16);
      feed(5, 16'h7000, 16'h7800);
      #2 reset_n = 0; #1;
      checks++;
      if ({in_ready, fifo_we, busy, done} !== 4'b0 || fifo_din !== '0 || lines_written !== 0) begin
         errors++;
         $display("FAIL async_reset: ready=%b we=%b busy=%b done=%b din_zero=%b lw=%0d, want all 0",
                  in_ready, fifo_we, busy, done, fifo_din == '0, lines_written);
      end
      @(negedge clk);
      reset_n = 1;
      @(negedge clk);
      begin_ctx(16);
      feed(16, 16'h6000, 16'h6800);
      #1;
      checks++;
      if (fifo_we !== 1'b1 || fifo_din !== exp) begin
         errors++; $display("FAIL after_reset_line: we=%b got %h want %h", fifo_we, fifo_din, exp);
      end
      @(negedge clk); @(negedge clk);
   endtask

   task automatic test_one_pair_per_line;
      int sent = 0, writes = 0, bad = 0;
      bit seen_done = 0;
      logic [31:0] lw_at_done = 0;
      logic [511:0] exp;
      start_1 = 1; ctx_length_1 = 3;
      @(negedge clk);
      start_1 = 0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         in_valid_1 = sent < 3 ? 1'($urandom_range(0, 1)) : 1'b0;
         in_a_1 = 16'h6100 + 16'(sent); in_b_1 = 16'h6200 + 16'(sent);
         #1;
         if (fifo_we_1) begin
            exp = '0;
            exp[31:0] = {16'h6200 + 16'(writes), 16'h6100 + 16'(writes)};
            if (fifo_din_1 !== exp) bad++;
            writes++;
         end
         if (done_1) begin seen_done = 1; lw_at_done = lines_written_1; end
         if (in_valid_1 && in_ready_1) sent++;
         @(negedge clk);
      end
      in_valid_1 = 0;
      checks++;
      if (!seen_done || writes != 3 || lw_at_done !== 32'd3) begin
         errors++; $display("FAIL ppl1_count: done=%b writes=%0d lw=%0d, want 1 3 3", seen_done, writes, lw_at_done);
      end
      checks++;
      if (bad != 0) begin
         errors++; $display("FAIL ppl1_data: %0d bad lines, want 0", bad);
      end
   endtask

   initial begin
      reset_n = 0;
      test_reset;
      test_single_line;
      test_partial_line;
      test_backpressure;
      test_zero_and_restart;
      test_async_reset;
      test_one_pair_per_line;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
